esm_dwell_sequencer_banked: RTL and testbench

//  Banked, parametrised successor to the ESM dwell controller. Runs dwell programs from one of NUM_BANKS instruction banks

---
 rtl/esm_dwell_sequencer_banked.sv | 271 +++++++++++++++++++++++++++
 tb/tb_esm_dwell_sequencer_banked.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esm_dwell_sequencer_banked.sv
// Banked ESM dwell sequencer: runs dwell programs from one of several
// instruction banks, sequences AD9361 fast-lock retunes, emits dwell metadata.
package esm_dwell_pkg;
    typedef struct packed {
        logic [7:0]  tag;
        logic [15:0] frequency;
        logic [15:0] duration;
        logic [7:0]  fast_lock_profile;
    } esm_dwell_metadata_t;

    typedef struct packed {
        logic       valid;
        logic       global_counter_check;
        logic       global_counter_dec;
        logic       skip_pll_prelock_wait;
        logic       skip_pll_lock_check;
        logic       skip_pll_postlock_wait;
        logic [7:0] repeat_count;
        logic [7:0] entry_index;
        logic [7:0] next_instruction_index;
    } esm_dwell_instruction_t;
endpackage

module esm_dwell_sequencer_banked
    import esm_dwell_pkg::*;
#(
    parameter int NUM_ENTRIES                = 16,
    parameter int NUM_INSTRUCTIONS           = 32,
    parameter int NUM_BANKS                  = 2,
    parameter int COUNTER_WIDTH              = 32,
    parameter int PLL_PRE_LOCK_DELAY_CYCLES  = 8,
    parameter int PLL_POST_LOCK_DELAY_CYCLES = 10,
    parameter int PLL_LOCK_TIMEOUT_CYCLES    = 1024,
    localparam int EW = $clog2(NUM_ENTRIES),
    localparam int IW = $clog2(NUM_INSTRUCTIONS),
    localparam int BW = $clog2(NUM_BANKS)
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Entry_wr_valid,
    input  logic [EW-1:0]            Entry_wr_index,
    input  esm_dwell_metadata_t      Entry_wr_data,
    input  logic                     Inst_wr_valid,
    input  logic [BW-1:0]            Inst_wr_bank,
    input  logic [IW-1:0]            Inst_wr_index,
    input  esm_dwell_instruction_t   Inst_wr_data,
    input  logic                     Program_start,
    input  logic [BW-1:0]            Program_bank,
    input  logic [COUNTER_WIDTH-1:0] Global_counter_init,
    input  logic                     Program_stop,
    input  logic                     Bank_swap_req,
    input  logic [BW-1:0]            Bank_swap_bank,
    output logic [3:0]               Ad9361_control,
    input  logic [7:0]               Ad9361_status,
    output logic                     Dwell_active,
    output esm_dwell_metadata_t      Dwell_data,
    output logic [31:0]              Dwell_sequence_num,
    output logic [BW-1:0]            Active_bank,
    output logic                     Program_running,
    output logic                     Pll_lock_error,
    output logic                     Wr_error
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH_INST, S_FETCH_ENTRY, S_CHECK, S_PLL_PRE,
        S_PLL_LOCK, S_PLL_POST, S_DWELL, S_NEXT
    } state_t;

    esm_dwell_metadata_t    entry_mem [NUM_ENTRIES];
    esm_dwell_instruction_t inst_mem  [NUM_BANKS][NUM_INSTRUCTIONS];

    state_t                 state_q;
    state_t                 after_lock;
    state_t                 after_pre;
    state_t                 after_chk;
    esm_dwell_metadata_t    entry_rd_q;
    esm_dwell_metadata_t    entry_q;
    esm_dwell_metadata_t    dwell_data_q;
    esm_dwell_instruction_t inst_rd_q;
    esm_dwell_instruction_t inst_q;
    logic [BW-1:0]          bank_q;
    logic [BW-1:0]          swap_bank_q;
    logic                   swap_pend_q;
    logic [IW-1:0]          idx_q;
    logic [7:0]             rep_q;
    logic [31:0]            wait_q;
    logic [COUNTER_WIDTH-1:0] gcnt_q;
    logic [31:0]            seq_cnt_q;
    logic [31:0]            seq_q;
    logic [3:0]             ad_q;
    logic                   active_q;
    logic                   pll_err_q;
    logic                   wr_err_q;
    logic                   running;
    logic                   wr_drop;
    logic [15:0]            dur_m1;
    logic                   unused_bits;

    assign running = (state_q != S_IDLE);
    assign wr_drop = Inst_wr_valid && running && (Inst_wr_bank == bank_q);
    assign dur_m1  = (entry_q.duration == 16'd0) ? 16'd0
                                                 : entry_q.duration - 16'd1;
    assign unused_bits = ^{inst_q, entry_q, Ad9361_status[6:0]};

    // Retune chain: each enabled wait stage is entered, skipped ones fall through
    always_comb begin
        after_lock = inst_q.skip_pll_postlock_wait ? S_DWELL : S_PLL_POST;
        after_pre  = inst_q.skip_pll_lock_check ? after_lock : S_PLL_LOCK;
        after_chk  = inst_q.skip_pll_prelock_wait ? after_pre : S_PLL_PRE;
    end

    always_ff @(posedge Clk) begin
        if (Entry_wr_valid) begin
            entry_mem[Entry_wr_index] <= Entry_wr_data;
        end
        if (Inst_wr_valid && !wr_drop) begin
            inst_mem[Inst_wr_bank][Inst_wr_index] <= Inst_wr_data;
        end
        inst_rd_q  <= inst_mem[bank_q][idx_q];
        entry_rd_q <= entry_mem[inst_q.entry_index[EW-1:0]];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= S_IDLE;
            entry_q      <= '0;
            inst_q       <= '0;
            dwell_data_q <= '0;
            bank_q       <= '0;
            swap_bank_q  <= '0;
            swap_pend_q  <= 1'b0;
            idx_q        <= '0;
            rep_q        <= '0;
            wait_q       <= '0;
            gcnt_q       <= '0;
            seq_cnt_q    <= '0;
            seq_q        <= '0;
            ad_q         <= '0;
            active_q     <= 1'b0;
            pll_err_q    <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            pll_err_q <= 1'b0;
            wr_err_q  <= wr_drop;
            unique case (state_q)
                S_IDLE: begin
                    if (Program_start && !Program_stop) begin
                        bank_q  <= Program_bank;
                        idx_q   <= '0;
                        gcnt_q  <= Global_counter_init;
                        wait_q  <= '0;
                        state_q <= S_FETCH_INST;
                    end else if (Bank_swap_req) begin
                        bank_q <= Bank_swap_bank;
                    end
                end
                S_FETCH_INST: begin
                    if (wait_q == 32'd0) begin
                        wait_q <= 32'd1;
                    end else begin
                        inst_q  <= inst_rd_q;
                        wait_q  <= '0;
                        rep_q   <= '0;
                        state_q <= inst_rd_q.valid ? S_FETCH_ENTRY : S_IDLE;
                    end
                end
                S_FETCH_ENTRY: begin
                    if (wait_q == 32'd0) begin
                        wait_q <= 32'd1;
                    end else begin
                        entry_q <= entry_rd_q;
                        wait_q  <= '0;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    wait_q <= '0;
                    if (inst_q.global_counter_check && gcnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else if (rep_q == 8'd0) begin
                        ad_q    <= entry_q.fast_lock_profile[3:0];
                        state_q <= after_chk;
                    end else begin
                        state_q <= S_DWELL;
                    end
                end
                S_PLL_PRE: begin
                    if (wait_q == 32'(PLL_PRE_LOCK_DELAY_CYCLES - 1)) begin
                        wait_q  <= '0;
                        state_q <= after_pre;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_PLL_LOCK: begin
                    if (Ad9361_status[7]) begin
                        wait_q  <= '0;
                        state_q <= after_lock;
                    end else if (wait_q == 32'(PLL_LOCK_TIMEOUT_CYCLES - 1)) begin
                        pll_err_q <= 1'b1;
                        wait_q    <= '0;
                        state_q   <= after_lock;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_PLL_POST: begin
                    if (wait_q == 32'(PLL_POST_LOCK_DELAY_CYCLES - 1)) begin
                        wait_q  <= '0;
                        state_q <= S_DWELL;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_DWELL: begin
                    // First cycle in this state launches the dwell
                    if (!active_q) begin
                        active_q     <= 1'b1;
                        dwell_data_q <= entry_q;
                        seq_q        <= seq_cnt_q;
                        seq_cnt_q    <= seq_cnt_q + 32'd1;
                        wait_q       <= 32'(dur_m1);
                        if (inst_q.global_counter_dec && gcnt_q != '0) begin
                            gcnt_q <= gcnt_q - COUNTER_WIDTH'(1);
                        end
                    end else if (wait_q == 32'd0) begin
                        active_q <= 1'b0;
                        state_q  <= S_NEXT;
                    end else begin
                        wait_q <= wait_q - 32'd1;
                    end
                end
                S_NEXT: begin
                    if (rep_q < inst_q.repeat_count) begin
                        rep_q   <= rep_q + 8'd1;
                        state_q <= S_CHECK;
                    end else begin
                        if (swap_pend_q) begin
                            bank_q      <= swap_bank_q;
                            idx_q       <= '0;
                            swap_pend_q <= 1'b0;
                        end else begin
                            idx_q <= inst_q.next_instruction_index[IW-1:0];
                        end
                        wait_q  <= '0;
                        state_q <= S_FETCH_INST;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (Bank_swap_req && running) begin
                swap_pend_q <= 1'b1;
                swap_bank_q <= Bank_swap_bank;
            end
            if (Program_stop) begin
                state_q  <= S_IDLE;
                active_q <= 1'b0;
            end
        end
    end

    assign Ad9361_control     = ad_q;
    assign Dwell_active       = active_q;
    assign Dwell_data         = dwell_data_q;
    assign Dwell_sequence_num = seq_q;
    assign Active_bank        = bank_q;
    assign Program_running    = running;
    assign Pll_lock_error     = pll_err_q;
    assign Wr_error           = wr_err_q;

endmodule

// File: tb/tb_esm_dwell_sequencer_banked.sv
// Directed bench for esm_dwell_sequencer_banked: programs, counter loops,
// lock timeout, bank swap, write protection, stop and reset.
module tb_esm_dwell_sequencer_banked;
    import esm_dwell_pkg::*;

    localparam logic [5:0] F_V     = 6'b100000;
    localparam logic [5:0] F_CHK   = 6'b010000;
    localparam logic [5:0] F_DEC   = 6'b001000;
    localparam logic [5:0] F_SPRE  = 6'b000100;
    localparam logic [5:0] F_SKIP  = 6'b000111;

    logic                   Clk = 1'b0;
    logic                   Rst;
    logic                   Entry_wr_valid;
    logic [3:0]             Entry_wr_index;
    esm_dwell_metadata_t    Entry_wr_data;
    logic                   Inst_wr_valid;
    logic [0:0]             Inst_wr_bank;
    logic [4:0]             Inst_wr_index;
    esm_dwell_instruction_t Inst_wr_data;
    logic                   Program_start;
    logic [0:0]             Program_bank;
    logic [31:0]            Global_counter_init;
    logic                   Program_stop;
    logic                   Bank_swap_req;
    logic [0:0]             Bank_swap_bank;
    logic [3:0]             Ad9361_control;
    logic [7:0]             Ad9361_status;
    logic                   Dwell_active;
    esm_dwell_metadata_t    Dwell_data;
    logic [31:0]            Dwell_sequence_num;
    logic [0:0]             Active_bank;
    logic                   Program_running;
    logic                   Pll_lock_error;
    logic                   Wr_error;

    int n_cmp = 0;
    int n_bad = 0;
    int durs[16] = '{1, 2, 2, 3, 4, 0, 1, 2, 50, 1, 1, 1, 1, 1, 1, 1};

    esm_dwell_metadata_t mon_data[$];
    logic [31:0]         mon_seq[$];
    logic [0:0]          mon_bank[$];
    int                  mon_len[$];
    logic                prev_act = 1'b0;
    int                  cur_len = 0;

    esm_dwell_sequencer_banked dut (
        .Clk(Clk), .Rst(Rst),
        .Entry_wr_valid(Entry_wr_valid), .Entry_wr_index(Entry_wr_index),
        .Entry_wr_data(Entry_wr_data),
        .Inst_wr_valid(Inst_wr_valid), .Inst_wr_bank(Inst_wr_bank),
        .Inst_wr_index(Inst_wr_index), .Inst_wr_data(Inst_wr_data),
        .Program_start(Program_start), .Program_bank(Program_bank),
        .Global_counter_init(Global_counter_init),
        .Program_stop(Program_stop),
        .Bank_swap_req(Bank_swap_req), .Bank_swap_bank(Bank_swap_bank),
        .Ad9361_control(Ad9361_control), .Ad9361_status(Ad9361_status),
        .Dwell_active(Dwell_active), .Dwell_data(Dwell_data),
        .Dwell_sequence_num(Dwell_sequence_num),
        .Active_bank(Active_bank), .Program_running(Program_running),
        .Pll_lock_error(Pll_lock_error), .Wr_error(Wr_error)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Dwell_active && !prev_act) begin
            mon_data.push_back(Dwell_data);
            mon_seq.push_back(Dwell_sequence_num);
            mon_bank.push_back(Active_bank);
            cur_len = 1;
        end else if (Dwell_active) begin
            cur_len++;
        end
        if (!Dwell_active && prev_act) mon_len.push_back(cur_len);
        prev_act = Dwell_active;
    end

    function automatic esm_dwell_metadata_t exp_entry(int k);
        esm_dwell_metadata_t e;
        e.tag               = 8'(8'h10 + k);
        e.frequency         = 16'(1000 + 37 * k);
        e.duration          = 16'(durs[k]);
        e.fast_lock_profile = 8'(8'hF0 | k);
        return e;
    endfunction

    function automatic int exp_len(int k);
        return (durs[k] == 0) ? 1 : durs[k];
    endfunction

    function automatic esm_dwell_metadata_t got_data(int i);
        return (i < mon_data.size()) ? mon_data[i] : '0;
    endfunction

    function automatic logic [31:0] got_seq(int i);
        return (i < mon_seq.size()) ? mon_seq[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic int got_len(int i);
        return (i < mon_len.size()) ? mon_len[i] : -1;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge Clk);
    endtask

    task automatic wr_entry(input int k);
        Entry_wr_valid = 1'b1;
        Entry_wr_index = 4'(k);
        Entry_wr_data  = exp_entry(k);
        tick();
        Entry_wr_valid = 1'b0;
    endtask

    task automatic wr_inst(input int bank, input int idx, input int rep,
                           input int ent, input int nxt,
                           input logic [5:0] fl);
        Inst_wr_valid = 1'b1;
        Inst_wr_bank  = 1'(bank);
        Inst_wr_index = 5'(idx);
        Inst_wr_data  = {fl, 8'(rep), 8'(ent), 8'(nxt)};
        tick();
        Inst_wr_valid = 1'b0;
    endtask

    task automatic start(input int bank, input int init);
        Program_bank        = 1'(bank);
        Global_counter_init = 32'(init);
        Program_start       = 1'b1;
        tick();
        Program_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!Program_running) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        Rst = 1'b1;
        tick(3);
        Rst = 1'b0;
        tick();
        n_cmp++;
        if ({Ad9361_control, Dwell_active, Dwell_data, Dwell_sequence_num,
             Active_bank, Program_running, Pll_lock_error, Wr_error} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ctrl=%h act=%b data=%h seq=%0d bank=%0d run=%b err=%b wr=%b want all 0",
                     Ad9361_control, Dwell_active, Dwell_data, Dwell_sequence_num,
                     Active_bank, Program_running, Pll_lock_error, Wr_error);
        end
    endtask

    task automatic test_basic;
        int b;
        bit ok;
        int ents[6] = '{3, 3, 3, 5, 7, 7};
        wr_inst(0, 0, 2, 3, 1, F_V);
        wr_inst(0, 1, 0, 5, 2, F_V | F_SKIP);
        wr_inst(0, 2, 1, 7, 31, F_V | F_SPRE);
        wr_inst(0, 31, 0, 0, 0, 6'b0);
        b = mon_data.size();
        start(0, 0);
        wait_idle(400, ok);
        tick(3);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL basic_idle: got running=1 want running=0");
        end
        n_cmp++;
        if (mon_data.size() - b != 6) begin
            n_bad++;
            $display("FAIL basic_count: got %0d want 6", mon_data.size() - b);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (got_data(b + i) !== exp_entry(ents[i])) begin
                n_bad++;
                $display("FAIL basic_data[%0d]: got %h want %h",
                         i, got_data(b + i), exp_entry(ents[i]));
            end
            n_cmp++;
            if (got_seq(b + i) !== 32'(i)) begin
                n_bad++;
                $display("FAIL basic_seq[%0d]: got %0d want %0d", i, got_seq(b + i), i);
            end
            n_cmp++;
            if (got_len(b + i) != exp_len(ents[i])) begin
                n_bad++;
                $display("FAIL basic_len[%0d]: got %0d want %0d",
                         i, got_len(b + i), exp_len(ents[i]));
            end
        end
        n_cmp++;
        if (Ad9361_control !== 4'h7) begin
            n_bad++;
            $display("FAIL basic_ctrl: got %h want 7", Ad9361_control);
        end
    endtask

    task automatic test_counter;
        int b;
        bit ok;
        wr_inst(0, 0, 0, 2, 0, F_V | F_CHK | F_DEC | F_SKIP);
        b = mon_data.size();
        start(0, 7);
        wait_idle(600, ok);
        tick(3);
        n_cmp++;
        if (!ok || mon_data.size() - b != 7) begin
            n_bad++;
            $display("FAIL counter7_count: got %0d (idle=%b) want 7", mon_data.size() - b, ok);
        end
        n_cmp++;
        if (got_data(b) !== exp_entry(2) || got_data(b + 6) !== exp_entry(2)) begin
            n_bad++;
            $display("FAIL counter7_data: got %h/%h want %h", got_data(b),
                     got_data(b + 6), exp_entry(2));
        end
        n_cmp++;
        if (got_seq(b) !== 32'd6 || got_seq(b + 6) !== 32'd12) begin
            n_bad++;
            $display("FAIL counter7_seq: got %0d..%0d want 6..12", got_seq(b), got_seq(b + 6));
        end
        b = mon_data.size();
        start(0, 0);
        wait_idle(100, ok);
        tick(3);
        n_cmp++;
        if (!ok || mon_data.size() != b) begin
            n_bad++;
            $display("FAIL counter0_count: got %0d (idle=%b) want 0", mon_data.size() - b, ok);
        end
    endtask

    task automatic test_pll_timeout;
        int b;
        int n;
        bit ok;
        wr_inst(0, 0, 0, 4, 31, F_V);
        b = mon_data.size();
        Ad9361_status = 8'h00;
        start(0, 0);
        n = 0;
        for (int i = 1; i <= 2000; i++) begin
            tick();
            if (Pll_lock_error) begin
                n = i;
                break;
            end
        end
        n_cmp++;
        if (n != 1037) begin
            n_bad++;
            $display("FAIL pll_err_latency: got %0d want 1037", n);
        end
        tick();
        n_cmp++;
        if (Pll_lock_error !== 1'b0) begin
            n_bad++;
            $display("FAIL pll_err_pulse: got %b want 0", Pll_lock_error);
        end
        wait_idle(200, ok);
        tick(3);
        Ad9361_status = 8'h80;
        n_cmp++;
        if (!ok || mon_data.size() - b != 1 || got_data(b) !== exp_entry(4)) begin
            n_bad++;
            $display("FAIL pll_dwell: got n=%0d data=%h want n=1 data=%h",
                     mon_data.size() - b, got_data(b), exp_entry(4));
        end
        n_cmp++;
        if (got_seq(b) !== 32'd13 || Ad9361_control !== 4'h4) begin
            n_bad++;
            $display("FAIL pll_seq_ctrl: got seq=%0d ctrl=%h want seq=13 ctrl=4",
                     got_seq(b), Ad9361_control);
        end
    endtask

    task automatic test_swap;
        int b;
        bit ok;
        bit seen;
        int ents[7] = '{1, 2, 3, 3, 3, 3, 6};
        wr_inst(0, 0, 0, 1, 1, F_V | F_SKIP);
        wr_inst(0, 1, 0, 2, 2, F_V | F_SKIP);
        wr_inst(0, 2, 3, 3, 0, F_V | F_SKIP);
        wr_inst(1, 0, 0, 6, 31, F_V | F_SKIP);
        wr_inst(1, 31, 0, 0, 0, 6'b0);
        b = mon_data.size();
        start(0, 0);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (Dwell_active && Dwell_data.tag == 8'h13) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        Bank_swap_req  = 1'b1;
        Bank_swap_bank = 1'b0;
        tick();
        Bank_swap_bank = 1'b1;
        tick();
        Bank_swap_req = 1'b0;
        wait_idle(400, ok);
        tick(3);
        n_cmp++;
        if (!seen || !ok || mon_data.size() - b != 7) begin
            n_bad++;
            $display("FAIL swap_count: got %0d (seen=%b idle=%b) want 7",
                     mon_data.size() - b, seen, ok);
        end
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (got_data(b + i) !== exp_entry(ents[i]) || got_seq(b + i) !== 32'(14 + i)) begin
                n_bad++;
                $display("FAIL swap_dwell[%0d]: got %h seq=%0d want %h seq=%0d", i,
                         got_data(b + i), got_seq(b + i), exp_entry(ents[i]), 14 + i);
            end
        end
        n_cmp++;
        if ((b + 6 < mon_bank.size() ? mon_bank[b + 6] : 1'bx) !== 1'b1
            || (b + 5 < mon_bank.size() ? mon_bank[b + 5] : 1'bx) !== 1'b0) begin
            n_bad++;
            $display("FAIL swap_dwell_bank: got last two dwells on wrong bank want 0 then 1");
        end
        n_cmp++;
        if (Active_bank !== 1'b1) begin
            n_bad++;
            $display("FAIL swap_active_bank: got %0d want 1", Active_bank);
        end
    endtask

    task automatic test_wr_error;
        int b;
        bit ok;
        wr_inst(0, 0, 0, 2, 0, F_V | F_CHK | F_DEC | F_SKIP);
        start(0, 50);
        tick(4);
        Inst_wr_valid = 1'b1;
        Inst_wr_bank  = 1'b0;
        Inst_wr_index = 5'd0;
        Inst_wr_data  = {F_V | F_SKIP, 8'd0, 8'd9, 8'd31};
        tick();
        Inst_wr_valid = 1'b0;
        n_cmp++;
        if (Wr_error !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_error_set: got %b want 1", Wr_error);
        end
        tick();
        n_cmp++;
        if (Wr_error !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_error_pulse: got %b want 0", Wr_error);
        end
        Inst_wr_valid = 1'b1;
        Inst_wr_bank  = 1'b1;
        tick();
        Inst_wr_valid = 1'b0;
        n_cmp++;
        if (Wr_error !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_idle_bank: got Wr_error=%b want 0", Wr_error);
        end
        Program_stop = 1'b1;
        tick();
        Program_stop = 1'b0;
        tick(3);
        b = mon_data.size();
        start(0, 2);
        wait_idle(200, ok);
        tick(3);
        n_cmp++;
        if (!ok || mon_data.size() - b != 2 || got_data(b + 1) !== exp_entry(2)) begin
            n_bad++;
            $display("FAIL wr_dropped_mem: got n=%0d data=%h want n=2 data=%h",
                     mon_data.size() - b, got_data(b + 1), exp_entry(2));
        end
        b = mon_data.size();
        start(1, 0);
        wait_idle(200, ok);
        tick(3);
        n_cmp++;
        if (!ok || mon_data.size() - b != 1 || got_data(b) !== exp_entry(9)) begin
            n_bad++;
            $display("FAIL wr_accepted_mem: got n=%0d data=%h want n=1 data=%h",
                     mon_data.size() - b, got_data(b), exp_entry(9));
        end
    endtask

    task automatic test_stop_reset;
        bit seen;
        wr_inst(0, 0, 0, 8, 31, F_V | F_SKIP);
        wr_inst(1, 0, 0, 10, 31, F_V);
        start(0, 0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (Dwell_active) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        tick(5);
        Program_stop = 1'b1;
        tick();
        Program_stop = 1'b0;
        n_cmp++;
        if (!seen || Dwell_active !== 1'b0 || Program_running !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_mid_dwell: got seen=%b act=%b run=%b want 1/0/0",
                     seen, Dwell_active, Program_running);
        end
        Ad9361_status = 8'h00;
        start(1, 0);
        tick(30);
        n_cmp++;
        if (Program_running !== 1'b1 || Ad9361_control !== 4'hA || Active_bank !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_state: got run=%b ctrl=%h bank=%0d want 1/a/1",
                     Program_running, Ad9361_control, Active_bank);
        end
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        n_cmp++;
        if ({Ad9361_control, Dwell_active, Dwell_data, Dwell_sequence_num,
             Active_bank, Program_running, Pll_lock_error, Wr_error} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_lock: got ctrl=%h act=%b data=%h seq=%0d bank=%0d run=%b want all 0",
                     Ad9361_control, Dwell_active, Dwell_data, Dwell_sequence_num,
                     Active_bank, Program_running);
        end
        Ad9361_status = 8'h80;
    endtask

    initial begin
        Rst                 = 1'b1;
        Entry_wr_valid      = 1'b0;
        Entry_wr_index      = '0;
        Entry_wr_data       = '0;
        Inst_wr_valid       = 1'b0;
        Inst_wr_bank        = '0;
        Inst_wr_index       = '0;
        Inst_wr_data        = '0;
        Program_start       = 1'b0;
        Program_bank        = '0;
        Global_counter_init = '0;
        Program_stop        = 1'b0;
        Bank_swap_req       = 1'b0;
        Bank_swap_bank      = '0;
        Ad9361_status       = 8'h80;
        test_reset();
        for (int k = 0; k < 16; k++) wr_entry(k);
        test_basic();
        test_counter();
        test_pll_timeout();
        test_swap();
        test_wr_error();
        test_stop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
